// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshake bundle for the ALU command sequencer.
// The master drives commands and accepts results; the slave is the sequencer.
interface alu_cmd_sequencer_if #(
  parameter int RAW = 3
);

  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [RAW-1:0]  cmd_dst;
  logic [RAW-1:0]  cmd_src_a;
  logic [RAW-1:0]  cmd_src_b;
  logic            cmd_imm_sel;
  logic [31:0]     cmd_imm;

  logic            res_valid;
  logic            res_ready;
  logic [31:0]     res_data;
  logic [RAW-1:0]  res_dst;

  modport master (
    output cmd_valid,
    input  cmd_ready,
    output cmd_op,
    output cmd_dst,
    output cmd_src_a,
    output cmd_src_b,
    output cmd_imm_sel,
    output cmd_imm,
    input  res_valid,
    output res_ready,
    input  res_data,
    input  res_dst
  );

  modport slave (
    input  cmd_valid,
    output cmd_ready,
    input  cmd_op,
    input  cmd_dst,
    input  cmd_src_a,
    input  cmd_src_b,
    input  cmd_imm_sel,
    input  cmd_imm,
    output res_valid,
    input  res_ready,
    output res_data,
    output res_dst
  );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// Register-addressed command front-end for a 32-bit combinational ALU.
// Reads operands from a small register file, drives the ALU from registers,
// writes the result back and offers it downstream over valid/ready.
module alu_cmd_sequencer #(
  parameter int NREGS = 8,
  parameter int RAW   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_cmd_sequencer_if.slave     bus,
  output logic [2:0]             alu_op,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  input  logic [31:0]            alu_y,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [31:0]     regs [NREGS];
  logic            res_valid;
  logic [31:0]     res_data;
  logic [RAW-1:0]  res_dst;

  // Register 0 is hard-wired to zero regardless of what the array holds.
  function automatic logic [31:0] read_reg(input logic [RAW-1:0] addr);
    logic [31:0] value;
    if (addr == '0) begin
      value = '0;
    end else begin
      value = regs[addr];
    end
    return value;
  endfunction

  // Handshake and status outputs are pure decodes of the registered state.
  assign bus.cmd_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data;
  assign bus.res_dst   = res_dst;

  // Sequencer FSM: capture operands, sample the ALU once, hold the result
  // until downstream takes it. Reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_dst   <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            alu_op  <= bus.cmd_op;
            alu_a   <= read_reg(bus.cmd_src_a);
            alu_b   <= bus.cmd_imm_sel ? bus.cmd_imm : read_reg(bus.cmd_src_b);
            res_dst <= bus.cmd_dst;
            state   <= EXEC;
          end
        end
        EXEC: begin
          res_data  <= alu_y;
          res_valid <= 1'b1;
          if (res_dst != '0) begin
            regs[res_dst] <= alu_y;
          end
          state <= RESP;
        end
        RESP: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer, with a behavioural
// model of the downstream combinational ALU.
module tb_alu_cmd_sequencer;

  localparam int NREGS = 8;
  localparam int RAW   = 3;

  localparam logic [2:0] OP_A   = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_INC = 3'b101;
  localparam logic [2:0] OP_DEC = 3'b110;
  localparam logic [2:0] OP_B   = 3'b111;

  logic        clk;
  logic        rst_n;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_cmd_sequencer_if #(.RAW(RAW)) bus ();

  alu_cmd_sequencer #(.NREGS(NREGS), .RAW(RAW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .alu_op (alu_op),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_y  (alu_y),
    .busy   (busy)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational ALU standing in for the real downstream block.
  always_comb begin
    alu_y = '0;
    case (alu_op)
      OP_A:    alu_y = alu_a;
      OP_ADD:  alu_y = alu_a + alu_b;
      OP_SUB:  alu_y = alu_a - alu_b;
      OP_AND:  alu_y = alu_a & alu_b;
      OP_OR:   alu_y = alu_a | alu_b;
      OP_INC:  alu_y = alu_a + 32'd1;
      OP_DEC:  alu_y = alu_a - 32'd1;
      default: alu_y = alu_b;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic driveCmd(input logic [2:0] op, input logic [RAW-1:0] dst,
                          input logic [RAW-1:0] src_a, input logic [RAW-1:0] src_b,
                          input logic imm_sel, input logic [31:0] imm);
    bus.cmd_op      = op;
    bus.cmd_dst     = dst;
    bus.cmd_src_a   = src_a;
    bus.cmd_src_b   = src_b;
    bus.cmd_imm_sel = imm_sel;
    bus.cmd_imm     = imm;
    bus.cmd_valid   = 1'b1;
  endtask

  // Issue one command with res_ready high and check the full 3-cycle round trip.
  task automatic applyStimulus(input string tag, input logic [2:0] op,
                               input logic [RAW-1:0] dst, input logic [RAW-1:0] src_a,
                               input logic [RAW-1:0] src_b, input logic imm_sel,
                               input logic [31:0] imm, input logic [31:0] expected);
    logic accepted;
    int   waitCycles;
    accepted   = 1'b0;
    waitCycles = 0;
    driveCmd(op, dst, src_a, src_b, imm_sel, imm);
    while (!accepted && waitCycles < 20) begin
      accepted = bus.cmd_ready;
      @(posedge clk);
      #1;
      waitCycles++;
    end
    bus.cmd_valid = 1'b0;
    checkOutput({tag, "_accept"}, 32'(accepted), 32'd1);
    if (accepted) begin
      checkOutput({tag, "_exec_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_exec_novalid"}, 32'(bus.res_valid), 32'd0);
      @(posedge clk);
      #1;
      checkOutput({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
      checkOutput({tag, "_data"}, bus.res_data, expected);
      checkOutput({tag, "_dst"}, 32'(bus.res_dst), 32'(dst));
      @(posedge clk);
      #1;
      checkOutput({tag, "_valid_drop"}, 32'(bus.res_valid), 32'd0);
      checkOutput({tag, "_ready_back"}, 32'(bus.cmd_ready), 32'd1);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.res_ready   = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = '0;
    bus.cmd_dst     = '0;
    bus.cmd_src_a   = '0;
    bus.cmd_src_b   = '0;
    bus.cmd_imm_sel = 1'b0;
    bus.cmd_imm     = '0;

    // Outputs during reset
    #12;
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("rst_res_data", bus.res_data, 32'd0);
    checkOutput("rst_res_dst", 32'(bus.res_dst), 32'd0);
    checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_alu_b", alu_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] immediate command after reset");
    applyStimulus("imm_first", OP_B, 3'd1, 3'd0, 3'd0, 1'b1, 32'h0000_0005, 32'h0000_0005);

    $display("[TB] chained add with read-after-write");
    applyStimulus("load_r2", OP_B, 3'd2, 3'd0, 3'd0, 1'b1, 32'd7, 32'd7);
    applyStimulus("add_1_2", OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0, 32'd12);
    applyStimulus("add_3_3", OP_ADD, 3'd3, 3'd3, 3'd3, 1'b0, 32'd0, 32'd24);

    $display("[TB] wrap-around");
    applyStimulus("load_r1_max", OP_B, 3'd1, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus("inc_wrap", OP_INC, 3'd4, 3'd1, 3'd0, 1'b0, 32'd0, 32'h0000_0000);
    applyStimulus("dec_wrap", OP_DEC, 3'd5, 3'd4, 3'd0, 1'b0, 32'd0, 32'hFFFF_FFFF);

    $display("[TB] register zero");
    applyStimulus("r0_write", OP_B, 3'd0, 3'd0, 3'd0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    applyStimulus("r0_read", OP_A, 3'd6, 3'd0, 3'd0, 1'b0, 32'd0, 32'd0);

    $display("[TB] backpressure");
    bus.res_ready = 1'b0;
    driveCmd(OP_AND, 3'd6, 3'd3, 3'd0, 1'b1, 32'h0000_000F);
    @(posedge clk);
    #1;
    checkOutput("bp_accept_busy", 32'(busy), 32'd1);
    driveCmd(OP_OR, 3'd7, 3'd3, 3'd0, 1'b1, 32'h0000_0100);
    @(posedge clk);
    #1;
    checkOutput("bp_valid", 32'(bus.res_valid), 32'd1);
    checkOutput("bp_data", bus.res_data, 32'd8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_hold_valid", 32'(bus.res_valid), 32'd1);
      checkOutput("bp_hold_data", bus.res_data, 32'd8);
      checkOutput("bp_hold_dst", 32'(bus.res_dst), 32'd6);
      checkOutput("bp_hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("bp_release_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    checkOutput("bp_queued_busy", 32'(busy), 32'd1);
    checkOutput("bp_queued_op", 32'(alu_op), 32'(OP_OR));
    checkOutput("bp_queued_a", alu_a, 32'd24);
    checkOutput("bp_queued_b", alu_b, 32'h0000_0100);
    @(posedge clk);
    #1;
    checkOutput("bp_queued_valid", 32'(bus.res_valid), 32'd1);
    checkOutput("bp_queued_data", bus.res_data, 32'h0000_0118);
    checkOutput("bp_queued_dst", 32'(bus.res_dst), 32'd7);
    @(posedge clk);
    #1;
    checkOutput("bp_queued_done", 32'(bus.cmd_ready), 32'd1);

    $display("[TB] reset mid-operation");
    applyStimulus("load_r2_9", OP_B, 3'd2, 3'd0, 3'd0, 1'b1, 32'd9, 32'd9);
    driveCmd(OP_SUB, 3'd2, 3'd2, 3'd0, 1'b1, 32'd4);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    checkOutput("mid_exec_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_data", bus.res_data, 32'd0);
    checkOutput("mid_rst_alu_a", alu_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_no_stale", 32'(bus.res_valid), 32'd0);
    applyStimulus("mid_read_r2", OP_A, 3'd0, 3'd2, 3'd0, 1'b0, 32'd0, 32'd0);
    applyStimulus("mid_read_r3", OP_A, 3'd0, 3'd3, 3'd0, 1'b0, 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
